// File: rtl/therm_dac_seq.sv
// therm_dac_seq: thermometer-code DAC sequencer.
// Produces sawtooth, triangle or static levels at a programmable step rate and
// drives an N-bit unit-element select vector whose popcount always equals the
// level. Define THERM_DAC_DWA_EN to enable data-weighted-averaging rotation of
// the selected elements; without it elements fill from bit 0 upward.
module therm_dac_seq #(
    parameter  int N     = 4,
    parameter  int DIV_W = 8,
    localparam int CW    = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [DIV_W-1:0] div,
    input  logic             load,
    input  logic [CW-1:0]    code_in,
    output logic [N-1:0]     b,
    output logic [CW-1:0]    count,
    output logic             dir,
    output logic             step
);

    localparam logic [CW-1:0] N_C = CW'(N);

    logic [DIV_W-1:0] pc_q, pc_d;
    logic [CW-1:0]    count_q, count_d;
    logic             dir_q, dir_d;
    logic             step_q, step_d;
    logic [N-1:0]     b_q, b_d;
    logic [N-1:0]     therm_d;
    logic [CW-1:0]    load_val;
    logic             wrap;
    logic             rising;
    logic             upd;

`ifdef THERM_DAC_DWA_EN
    localparam int PW = $clog2(N);
    localparam int SW = CW + 1;
    logic [PW-1:0] ptr_q, ptr_d;
`endif

    assign load_val = (code_in > N_C) ? N_C : code_in;
    assign wrap     = en && (pc_q == div);

    // Prescaler, level and direction update; load overrides a coincident wrap.
    always_comb begin
        pc_d    = pc_q;
        count_d = count_q;
        dir_d   = dir_q;
        step_d  = 1'b0;
        upd     = 1'b0;
        rising  = dir_q;
        if (load) begin
            count_d = load_val;
            pc_d    = '0;
            dir_d   = (load_val != N_C);
            upd     = 1'b1;
        end else if (wrap) begin
            pc_d   = '0;
            step_d = 1'b1;
            case (mode)
                2'd0: begin
                    count_d = (count_q == N_C) ? '0 : count_q + CW'(1);
                    dir_d   = 1'b1;
                    upd     = 1'b1;
                end
                2'd1: begin
                    // At either rail the only legal move is away from it,
                    // whatever dir was left behind by another mode.
                    if (count_q == '0)
                        rising = 1'b1;
                    else if (count_q == N_C)
                        rising = 1'b0;
                    if (rising) begin
                        count_d = count_q + CW'(1);
                        dir_d   = (count_d != N_C);
                    end else begin
                        count_d = count_q - CW'(1);
                        dir_d   = (count_d == '0);
                    end
                    upd = 1'b1;
                end
                default: begin
                    // static: level held, only the step pulse is produced
                end
            endcase
        end else if (en) begin
            pc_d = pc_q + DIV_W'(1);
        end
    end

    // Thermometer code of the level being written this edge.
    for (genvar gi = 0; gi < N; gi++) begin : g_therm
        assign therm_d[gi] = (count_d > CW'(gi));
    end

`ifdef THERM_DAC_DWA_EN
    // Rotate the new code by the pointer, then advance the pointer past the
    // elements just used so consecutive codes walk around the array.
    always_comb begin
        b_d   = b_q;
        ptr_d = ptr_q;
        if (upd) begin
            b_d   = N'(({therm_d, therm_d} << ptr_q) >> N);
            ptr_d = PW'(((SW'(ptr_q) + SW'(count_d)) >= SW'(N))
                        ? (SW'(ptr_q) + SW'(count_d) - SW'(N))
                        : (SW'(ptr_q) + SW'(count_d)));
        end
    end
`else
    // Fixed element order: select vector is the plain thermometer code.
    always_comb begin
        b_d = upd ? therm_d : b_q;
    end
`endif

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= '0;
            count_q <= '0;
            dir_q   <= 1'b1;
            step_q  <= 1'b0;
            b_q     <= '0;
`ifdef THERM_DAC_DWA_EN
            ptr_q   <= '0;
`endif
        end else begin
            pc_q    <= pc_d;
            count_q <= count_d;
            dir_q   <= dir_d;
            step_q  <= step_d;
            b_q     <= b_d;
`ifdef THERM_DAC_DWA_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    assign b     = b_q;
    assign count = count_q;
    assign dir   = dir_q;
    assign step  = step_q;

endmodule

// File: tb/tb_therm_dac_seq.sv
// Testbench for therm_dac_seq (N=4, DIV_W=8): cycle-level reference model plus
// directed sequences with literal expectations. Works with or without
// THERM_DAC_DWA_EN defined.
module tb_therm_dac_seq;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic [DW-1:0] div = '0;
    logic          load = 1'b0;
    logic [CW-1:0] code_in = '0;
    logic [N-1:0]  b;
    logic [CW-1:0] count;
    logic          dir;
    logic          step;

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 1'b0;

    therm_dac_seq #(.N(N), .DIV_W(DW)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .div(div),
        .load(load), .code_in(code_in), .b(b), .count(count),
        .dir(dir), .step(step)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- reference model ----------------
    int         m_pc, m_cnt, m_ptr, m_new;
    bit         m_dir, m_step, m_up;
    logic [N-1:0] m_b;

    // Element pattern for level c starting at element p (wrapping).
    function automatic logic [N-1:0] elem(input int c, input int p);
        int t, r;
        t = (1 << c) - 1;
        r = ((t << p) | (t >> (N - p))) & ((1 << N) - 1);
        return N'(r);
    endfunction

    function automatic int popc(input logic [N-1:0] v);
        int s = 0;
        for (int i = 0; i < N; i++) s += int'(v[i]);
        return s;
    endfunction

    task automatic m_write(input int c);
        m_cnt = c;
`ifdef THERM_DAC_DWA_EN
        m_b   = elem(c, m_ptr);
        m_ptr = (m_ptr + c) % N;
`else
        m_b   = elem(c, 0);
`endif
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_pc = 0; m_cnt = 0; m_dir = 1; m_step = 0; m_ptr = 0; m_b = '0;
        end else if (load) begin
            m_new = (int'(code_in) > N) ? N : int'(code_in);
            m_write(m_new);
            m_pc = 0; m_dir = (m_new != N); m_step = 0;
        end else if (en && m_pc == int'(div)) begin
            m_pc = 0; m_step = 1;
            if (mode == 2'd0) begin
                m_write((m_cnt + 1) % (N + 1));
                m_dir = 1;
            end else if (mode == 2'd1) begin
                m_up = (m_cnt == 0) ? 1'b1 : (m_cnt == N) ? 1'b0 : m_dir;
                m_new = m_up ? m_cnt + 1 : m_cnt - 1;
                m_write(m_new);
                m_dir = m_up ? (m_new != N) : (m_new == 0);
            end
        end else begin
            if (en) m_pc = (m_pc + 1) % (1 << DW);
            m_step = 0;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_count", count, m_cnt);
            chk("m_b", b, m_b);
            chk("m_dir", dir, m_dir);
            chk("m_step", step, m_step);
            chk("popcount", popc(b), count);
        end
    end

    // ---------------- directed stimulus ----------------
    int saw_cnt [6] = '{1, 2, 3, 4, 0, 1};
    int saw_b   [6] = '{1, 3, 7, 15, 0, 1};
    int tri_cnt [10] = '{1, 2, 3, 4, 3, 2, 1, 0, 1, 2};
    int tri_dir [10] = '{1, 1, 1, 0, 0, 0, 0, 1, 1, 1};
`ifdef THERM_DAC_DWA_EN
    int seq_b   [5] = '{1, 6, 11, 15, 0};
    int frz_b = 6;
`else
    int seq_b   [5] = '{1, 3, 7, 15, 0};
    int frz_b = 3;
`endif
    int steps, gap;

    initial begin
        // Reset with en/load asserted.
        rst = 1; en = 1; load = 1; code_in = 3'd3; mode = 2'd0; div = 8'd2;
        tick(2);
        rst = 0; load = 0; en = 0;
        chk_en = 1;
        chk("rst_count", count, 0);
        chk("rst_b", b, 0);
        chk("rst_dir", dir, 1);
        chk("rst_step", step, 0);

        // Sawtooth, div 2: one step every 3 cycles.
        en = 1; steps = 0; gap = 0;
        for (int cyc = 0; cyc < 40 && steps < 6; cyc++) begin
            tick(1);
            gap++;
            if (step) begin
                chk("saw_cnt", count, saw_cnt[steps]);
`ifndef THERM_DAC_DWA_EN
                chk("saw_b", b, saw_b[steps]);
`endif
                chk("saw_gap", gap, 3);
                gap = 0;
                steps++;
            end
        end
        if (steps < 6) chk("saw_timeout", steps, 6);

        // Triangle, div 0, with an en gap at level 2.
        rst = 1; tick(1); rst = 0; mode = 2'd1; div = 8'd0;
        for (int i = 0; i < 10; i++) begin
            if (i == 2) begin
                en = 0;
                for (int k = 0; k < 5; k++) begin
                    tick(1);
                    chk("frz_cnt", count, 2);
                    chk("frz_b", b, frz_b);
                    chk("frz_dir", dir, 1);
                    chk("frz_step", step, 0);
                end
                en = 1;
            end
            tick(1);
            chk("tri_cnt", count, tri_cnt[i]);
            chk("tri_dir", dir, tri_dir[i]);
            chk("tri_step", step, 1);
        end

        // Load 7 clamps to 4 and beats the coincident wrap.
        rst = 1; mode = 2'd0; div = 8'd2; tick(1);
        rst = 0; en = 1; tick(2);
        load = 1; code_in = 3'd7; tick(1);
        load = 0; mode = 2'd2;
        chk("ld_cnt", count, 4);
        chk("ld_b", b, 15);
        chk("ld_dir", dir, 0);
        chk("ld_step", step, 0);
        tick(2);
        chk("st_nostep", step, 0);
        tick(1);
        chk("st_step", step, 1);
        chk("st_cnt", count, 4);
        tick(3);
        chk("st_step2", step, 1);
        chk("st_cnt2", count, 4);

        // Load with en low.
        en = 0; load = 1; code_in = 3'd2; tick(1);
        load = 0;
        chk("lden_cnt", count, 2);
        chk("lden_b", b, 3);
        chk("lden_dir", dir, 1);

        // Element sequence from reset, sawtooth at full rate.
        rst = 1; tick(1);
        rst = 0; mode = 2'd0; div = 8'd0; en = 1;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("seq_b", b, seq_b[i]);
        end

        // Triangle up to 4 and back to 3, then reset mid-ramp.
        mode = 2'd1;
        tick(5);
        chk("mid_cnt", count, 3);
        chk("mid_dir", dir, 0);
        rst = 1; tick(1);
        chk("rst2_cnt", count, 0);
        chk("rst2_dir", dir, 1);
        chk("rst2_b", b, 0);
        rst = 0; mode = 2'd0; tick(1);
        chk("rst2_next_cnt", count, 1);
        chk("rst2_next_b", b, 1);

        // Lower div below pc: pc runs to 255, wraps, then steps at pc == 1.
        div = 8'd5; tick(4);
        div = 8'd1; gap = 0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            tick(1);
            gap++;
            if (step) break;
        end
        chk("div_low_gap", gap, 254);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/therm_dac_seq.md
# therm_dac_seq

Parametrised thermometer-code DAC sequencer driving the unit-element switches of an N-element current/capacitor DAC. Generates sawtooth, triangle or static codes at a programmable step rate, and outputs both the binary level and the N-bit element-select vector. An optional data-weighted-averaging (DWA) rotation spreads element usage to shape mismatch.

## Interface
- N, default 4: number of unit elements; legal range 2..64.
- DIV_W, default 8: width of step-rate divider.
- CW (localparam) = $clog2(N+1): level width.

- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  enable; when low, prescaler, count, dir, ptr and b hold.
- mode  in  2  0 sawtooth, 1 triangle, 2 static, 3 static (reserved alias).
- div  in  DIV_W  a step occurs every div+1 enabled cycles.
- load  in  1  load code_in this cycle; works regardless of en.
- code_in  in  CW  level to load; values > N clamp to N.
- b  out  N  element select; popcount(b) == count at all times.
- count  out  CW  current level, 0..N.
- dir  out  1  1 = rising, 0 = falling; meaningful in triangle mode.
- step  out  1  one-cycle pulse coincident with each prescaler wrap.

## Operation
- Reset values: count 0, b 0, dir 1, step 0, prescaler pc 0, DWA pointer ptr 0.
- Prescaler: on an enabled cycle, if pc == div then pc <= 0 and an advance event fires, else pc <= pc+1. div sampled every cycle; lowering div below pc causes pc to count up to DIV_W wrap and then return to 0 — verified, not an error.
- Advance, mode 0: count <= (count == N) ? 0 : count+1; dir held at 1.
- Advance, mode 1: if dir, count+1, and at count == N-1 → N with dir <= 0 on same edge... precisely: rising: next = count+1; if next == N then dir <= 0. Falling: next = count-1; if next == 0 then dir <= 1. Sequence for N=4: 0,1,2,3,4,3,2,1,0,1...
- Advance, modes 2/3: count held; step still pulses.
- Mode change takes effect at the next advance; count and dir are not reset by it. Entering mode 1 with dir 0 at count 0 rises on next advance (dir forced to 1 when count == 0).
- load: count <= min(code_in, N), pc <= 0, dir <= 1 (0 if loaded value == N). load has priority over a coincident advance; no step pulse from that cycle's wrap.
- Update event = any edge where count is written (advance or load). b is recomputed on the same edge as count from the new value, so b and count are always consistent (no lag).
- rst has priority over load and en.

## Timing
- step registered: high in the cycle where the new count is visible; never high two consecutive cycles unless div == 0.
- div == 0 with en held high: count advances every cycle; step continuously high.
- Latency load → count/b: 1 cycle. First advance after reset with en high: div+1 cycles.

## Configuration
- THERM_DAC_DWA_EN defined: on each update event with new level c, b <= rotate_left(therm(c), ptr) within N bits, then ptr <= (ptr + c) mod N (ptr width $clog2(N)). ptr resets to 0; load and advance both rotate. therm(c) = c LSBs set.
- Not defined: b <= therm(count); no ptr register; element usage fixed from bit 0 upward.

## Test plan
- Reset: N=4, assert rst 2 cycles with en/load high → count 0, b 0000, dir 1, step 0 after release.
- Sawtooth: mode 0, div 2, en high → count steps every 3 cycles 1,2,3,4,0,1; b 0001,0011,0111,1111,0000; step one cycle per step.
- Triangle + en gap: mode 1, div 0 → 0,1,2,3,4,3,2,1,0,1 with dir falling at count 4, rising at 0; drop en for 5 cycles mid-ramp → all outputs frozen.
- Load priority/clamp: load code_in 7 (N=4) on same cycle as prescaler wrap → count 4, b 1111, dir 0, pc 0, no step; mode 2 then holds 4 with step pulses.
- DWA (THERM_DAC_DWA_EN, N=4, mode 0, div 0) → b sequence 0001, 0110, 1011, 1111, 0000, popcount(b) == count every cycle.
- Reset mid-ramp at count 3 in triangle falling → next cycle count 0, dir 1, ptr 0.
